riscv_alu_arbiter: RTL
======================

Name: riscv_alu_arbiter

Overview:
- Shares one combinational 32-bit RV32I ALU between two requesters: requester 0 is the execute stage, requester 1 is the branch-compare / address-generation unit.
- Each requester has a valid/ready request channel carrying A, B and a 4-bit function code.
- Grants are round-robin. Operands are registered, the ALU result and zero flag are captured, and a response is returned to the owning requester on its own valid/ready channel.
- One operation is in flight at a time.

Parameters:
- XLEN, 32, operand/result width
- FXW, 4, ALU function-code width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_valid  in  1  requester 0 request valid
- r0_ready  out  1  requester 0 request accepted this cycle when r0_valid&r0_ready
- r0_a  in  XLEN  requester 0 operand A
- r0_b  in  XLEN  requester 0 operand B
- r0_fx  in  FXW  requester 0 function code
- r0_rsp_valid  out  1  requester 0 response valid
- r0_rsp_ready  in  1  requester 0 response accept
- r0_rsp_data  out  XLEN  requester 0 result
- r0_rsp_zero  out  1  requester 0 compare/zero flag
- r0_rsp_err  out  1  requester 0 illegal function code (1110/1111)
- r1_valid, r1_ready, r1_a, r1_b, r1_fx, r1_rsp_valid, r1_rsp_ready, r1_rsp_data, r1_rsp_zero, r1_rsp_err: same as r0_*, for requester 1
- alu_a  out  XLEN  ALU operand A (registered)
- alu_b  out  XLEN  ALU operand B (registered)
- alu_fx  out  FXW  ALU function code (registered)
- alu_out  in  XLEN  ALU result (combinational from alu_a/alu_b/alu_fx)
- alu_zero  in  1  ALU zero/compare flag
- busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (rst_n=0, immediate):
  - state=IDLE, priority pointer=0.
  - alu_a=alu_b=0, alu_fx=0.
  - All rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, busy=0.
  - Any in-flight operation or pending response is discarded.
- States: IDLE, EXEC, RESP.
- IDLE:
  - rN_ready=1 only for the granted requester, combinationally.
  - Grant: if only one valid, that one. If both valid, the one named by the priority pointer.
  - On handshake: alu_a/alu_b/alu_fx <= that requester's a/b/fx; owner <= N; priority pointer <= 1-N; next state EXEC.
  - No valid: stay IDLE, ALU operand registers hold.
- EXEC (exactly 1 cycle):
  - The ALU evaluates the registered operands.
  - At the edge, the owner's rsp_data <= alu_out and rsp_zero <= alu_zero.
  - rsp_err <= (alu_fx==4'b1110 or 4'b1111); when set, rsp_data <= 0 and rsp_zero <= 0.
  - Owner's rsp_valid <= 1; next state RESP.
  - Both rN_ready=0.
- RESP:
  - Owner's rsp_valid held high with stable data, zero and err until rsp_ready=1.
  - On handshake: rsp_valid <= 0, next state IDLE. The non-owner's rsp_valid stays 0.
  - Both rN_ready=0.
- Timing: accept at edge k, rsp_valid high from edge k+2. Minimum issue interval is 3 cycles (RESP->IDLE bubble). A request cannot be accepted in the cycle its predecessor's response is accepted.
- A requester holds valid/a/b/fx stable until its ready. Deasserting valid before grant withdraws the request; no state change.
- The priority pointer updates only on grant. A single requester gets back-to-back grants regardless of the pointer.
- Only arbitration and sequencing happen here; result arithmetic is the ALU's (XLEN-bit wrap, shift amount = full B value as the ALU defines).
- busy = (state != IDLE).

Test Plan:
- Reset mid-RESP: r0 add 5+7 accepted, rst_n pulsed low during RESP -> r0_rsp_valid drops immediately, state IDLE, alu_a=alu_b=0, priority pointer=0.
- Single request: r0 issues A=5, B=7, fx=0000 at edge k -> alu_a=5, alu_b=7 after k; r0_rsp_valid=1 from k+2 with data=12, zero=0, err=0; with r0_rsp_ready=1 at k+2, r0_ready=1 again at k+3.
- Simultaneous requests after reset: r0 SUB 10-3, r1 SEQ 4==4 both valid -> r0 granted first, r0_rsp_data=7; then r1 granted, r1_rsp_data=1, zero=1; r1_rsp_valid never overlaps r0_rsp_valid.
- Back-pressure: r1 SLTU 1<2 with r1_rsp_ready=0 for 5 cycles -> r1_rsp_valid, data=1, zero=1 held stable for all 5 cycles; r0_valid held high meanwhile with r0_ready=0 throughout.
- Round-robin fairness: both requesters continuously valid for 12 operations -> grants alternate 0,1,0,1..., each requester completes 6.
- Illegal code: r1 fx=1111, A=B=0xFFFFFFFF -> r1_rsp_err=1, data=0, zero=0; the next legal r1 XOR 0xF0F0^0x0FF0 returns 0xFF00 with err=0.

Source files
------------

// File: rtl/riscv_alu_arbiter.sv
// riscv_alu_arbiter
// Lets the execute stage (requester 0) and the branch/AGU unit (requester 1)
// share one external combinational RV32I ALU. Grants are round-robin, and
// only one operation is in flight at a time. Operands are registered toward
// the ALU. The result is captured after one EXEC cycle and held on the
// owner's response channel until that requester accepts it.
module riscv_alu_arbiter #(
    parameter int XLEN = 32,
    parameter int FXW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    // requester 0 (execute stage)
    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [XLEN-1:0] r0_a,
    input  logic [XLEN-1:0] r0_b,
    input  logic [FXW-1:0]  r0_fx,
    output logic            r0_rsp_valid,
    input  logic            r0_rsp_ready,
    output logic [XLEN-1:0] r0_rsp_data,
    output logic            r0_rsp_zero,
    output logic            r0_rsp_err,
    // requester 1 (branch compare / address generation)
    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [XLEN-1:0] r1_a,
    input  logic [XLEN-1:0] r1_b,
    input  logic [FXW-1:0]  r1_fx,
    output logic            r1_rsp_valid,
    input  logic            r1_rsp_ready,
    output logic [XLEN-1:0] r1_rsp_data,
    output logic            r1_rsp_zero,
    output logic            r1_rsp_err,
    // shared ALU
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [FXW-1:0]  alu_fx,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    // Function codes 1110 and 1111 are reserved; the ALU output is meaningless for them.
    function automatic logic f_illegal_fx(input logic [FXW-1:0] fx);
        return (fx == FXW'(4'b1110)) || (fx == FXW'(4'b1111));
    endfunction

    logic [1:0]      r_state;
    logic            r_ptr;      // requester preferred when both are valid
    logic            r_owner;    // requester whose operation is in flight
    logic            r_busy;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [FXW-1:0]  r_alu_fx;
    logic            r_rsp_valid0;
    logic            r_rsp_valid1;
    logic [XLEN-1:0] r_rsp_data0;
    logic [XLEN-1:0] r_rsp_data1;
    logic            r_rsp_zero0;
    logic            r_rsp_zero1;
    logic            r_rsp_err0;
    logic            r_rsp_err1;

    logic [1:0]      w_state_nxt;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_rsp_hs;
    logic            w_err;
    logic [XLEN-1:0] w_data;
    logic            w_zero;

    // Grant selection, response handshake detection and next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r0_valid && (!r1_valid || !r_ptr)) begin
                    w_gnt0 = 1'b1;
                end else if (r1_valid) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b0;
                end
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (r_owner) begin
                    w_rsp_hs = r_rsp_valid1 && r1_rsp_ready;
                end else begin
                    w_rsp_hs = r_rsp_valid0 && r0_rsp_ready;
                end
                if (w_rsp_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reserved codes return a clean zero result with the error flag set.
    always_comb begin
        w_err = f_illegal_fx(r_alu_fx);
        if (w_err) begin
            w_data = {XLEN{1'b0}};
            w_zero = 1'b0;
        end else begin
            w_data = alu_out;
            w_zero = alu_zero;
        end
    end

    // Sequencer state, round-robin pointer, owner and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_gnt0) begin
                r_owner <= 1'b0;
                r_ptr   <= 1'b1;
            end else if (w_gnt1) begin
                r_owner <= 1'b1;
                r_ptr   <= 1'b0;
            end else begin
                r_owner <= r_owner;
                r_ptr   <= r_ptr;
            end
        end
    end

    // Operand registers feeding the ALU, loaded only on a request handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= {XLEN{1'b0}};
            r_alu_b  <= {XLEN{1'b0}};
            r_alu_fx <= {FXW{1'b0}};
        end else if (w_gnt0) begin
            r_alu_a  <= r0_a;
            r_alu_b  <= r0_b;
            r_alu_fx <= r0_fx;
        end else if (w_gnt1) begin
            r_alu_a  <= r1_a;
            r_alu_b  <= r1_b;
            r_alu_fx <= r1_fx;
        end else begin
            r_alu_a  <= r_alu_a;
            r_alu_b  <= r_alu_b;
            r_alu_fx <= r_alu_fx;
        end
    end

    // Response registers: capture into the owner's slot in EXEC, release on its handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_data0  <= {XLEN{1'b0}};
            r_rsp_data1  <= {XLEN{1'b0}};
            r_rsp_zero0  <= 1'b0;
            r_rsp_zero1  <= 1'b0;
            r_rsp_err0   <= 1'b0;
            r_rsp_err1   <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            if (r_owner) begin
                r_rsp_valid1 <= 1'b1;
                r_rsp_data1  <= w_data;
                r_rsp_zero1  <= w_zero;
                r_rsp_err1   <= w_err;
            end else begin
                r_rsp_valid0 <= 1'b1;
                r_rsp_data0  <= w_data;
                r_rsp_zero0  <= w_zero;
                r_rsp_err0   <= w_err;
            end
        end else if (w_rsp_hs) begin
            if (r_owner) begin
                r_rsp_valid1 <= 1'b0;
            end else begin
                r_rsp_valid0 <= 1'b0;
            end
        end else begin
            r_rsp_valid0 <= r_rsp_valid0;
            r_rsp_valid1 <= r_rsp_valid1;
        end
    end

    assign r0_ready     = w_gnt0;
    assign r1_ready     = w_gnt1;
    assign r0_rsp_valid = r_rsp_valid0;
    assign r0_rsp_data  = r_rsp_data0;
    assign r0_rsp_zero  = r_rsp_zero0;
    assign r0_rsp_err   = r_rsp_err0;
    assign r1_rsp_valid = r_rsp_valid1;
    assign r1_rsp_data  = r_rsp_data1;
    assign r1_rsp_zero  = r_rsp_zero1;
    assign r1_rsp_err   = r_rsp_err1;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_fx       = r_alu_fx;
    assign busy         = r_busy;

endmodule
